hh_membrane_update: RTL and testbench

Euler integrator for the Hodgkin-Huxley membrane potential, the consumer side of the gating-variable updaters. It takes the current membrane potential, the m, h and n gates (scale 1000 = 1.0), an injected current and a time step. It computes the Na, K and leak currents over a multi-cycle sequence on one shared multiplier, then returns the next membrane potential with a start/done handshake. Its `v_next` feeds back as `V` to the m/h/n gate blocks on the next neuron step.

---
 rtl/hh_membrane_update.sv | 185 ++++++++++++++++++
 tb/tb_hh_membrane_update.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hh_membrane_update.sv
// Hodgkin-Huxley membrane potential Euler step.
// A 13-state sequence shares one multiplier to form the Na, K and leak currents, sums them with
// the injected current, scales by dt and returns a saturated 16-bit potential with start/done.
module hh_membrane_update #(
   parameter int G_NA   = 1200,
   parameter int G_K    = 360,
   parameter int G_L    = 3,
   parameter int E_NA   = 5000,
   parameter int E_K    = -7700,
   parameter int E_L    = -5440,
   parameter int V_REST = -6500
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic signed [15:0] v_in,
   input  logic        [15:0] m_in,
   input  logic        [15:0] h_in,
   input  logic        [15:0] n_in,
   input  logic signed [15:0] i_ext,
   input  logic        [15:0] dt,
   output logic signed [15:0] v_next,
   output logic               busy,
   output logic               done
);

   typedef logic signed [63:0] dp_t;

   typedef enum logic [3:0] {
      StIdle,
      StNa1,
      StNa2,
      StNa3,
      StNa4,
      StNa5,
      StK1,
      StK2,
      StK3,
      StK4,
      StL,
      StSum,
      StScale,
      StUpd
   } state_t;

   localparam dp_t GNaDp       = dp_t'(G_NA);
   localparam dp_t GKDp        = dp_t'(G_K);
   localparam dp_t GLDp        = dp_t'(G_L);
   localparam dp_t ENaDp       = dp_t'(E_NA);
   localparam dp_t EKDp        = dp_t'(E_K);
   localparam dp_t ELDp        = dp_t'(E_L);
   localparam dp_t Thousand    = dp_t'(1000);
   localparam dp_t TenThousand = dp_t'(10000);
   localparam dp_t VMax        = dp_t'(32767);
   localparam dp_t VMin        = dp_t'(-32768);

   localparam logic signed [15:0] VRest = 16'(V_REST);

   state_t             state_q;
   logic signed [15:0] v_q;
   logic        [15:0] m_q;
   logic        [15:0] h_q;
   logic        [15:0] n_q;
   logic signed [15:0] i_ext_q;
   logic        [15:0] dt_q;
   dp_t                a_q;
   dp_t                b_q;
   dp_t                t_q;
   dp_t                i_na_q;
   dp_t                i_k_q;
   dp_t                i_l_q;
   dp_t                s_q;
   dp_t                p_q;

   dp_t                v_ext;
   dp_t                op_a;
   dp_t                op_b;
   dp_t                prod;
   dp_t                prod_div;
   dp_t                v_sum;
   logic signed [15:0] v_sat;

   // Gate values are fractions of 1000; anything larger is treated as fully open.
   function automatic logic [15:0] clamp_gate(input logic [15:0] g);
      return (g > 16'd1000) ? 16'd1000 : g;
   endfunction

   // Operand select for the single shared multiplier, plus the final update arithmetic.
   always_comb begin
      v_ext = dp_t'(v_q);
      op_a  = '0;
      op_b  = '0;
      case (state_q)
         StNa1:   begin op_a = dp_t'(m_q); op_b = dp_t'(m_q);  end
         StNa2:   begin op_a = a_q;        op_b = dp_t'(m_q);  end
         StNa3:   begin op_a = a_q;        op_b = dp_t'(h_q);  end
         StNa4:   begin op_a = a_q;        op_b = GNaDp;       end
         StNa5:   begin op_a = t_q;        op_b = v_ext - ENaDp; end
         StK1:    begin op_a = dp_t'(n_q); op_b = dp_t'(n_q);  end
         StK2:    begin op_a = b_q;        op_b = b_q;         end
         StK3:    begin op_a = b_q;        op_b = GKDp;        end
         StK4:    begin op_a = t_q;        op_b = v_ext - EKDp; end
         StL:     begin op_a = GLDp;       op_b = v_ext - ELDp; end
         StScale: begin op_a = s_q;        op_b = dp_t'(dt_q); end
         default: begin op_a = '0;         op_b = '0;          end
      endcase
      prod     = op_a * op_b;
      // Signed division truncates toward zero.
      prod_div = prod / Thousand;
      v_sum    = v_ext + (p_q / TenThousand);
      if (v_sum > VMax) begin
         v_sat = 16'sh7fff;
      end else if (v_sum < VMin) begin
         v_sat = -16'sh8000;
      end else begin
         v_sat = v_sum[15:0];
      end
   end

   // Sequencer: latches inputs in idle, then performs one datapath step per state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         v_q     <= '0;
         m_q     <= '0;
         h_q     <= '0;
         n_q     <= '0;
         i_ext_q <= '0;
         dt_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         t_q     <= '0;
         i_na_q  <= '0;
         i_k_q   <= '0;
         i_l_q   <= '0;
         s_q     <= '0;
         p_q     <= '0;
         v_next  <= VRest;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  v_q     <= v_in;
                  m_q     <= clamp_gate(m_in);
                  h_q     <= clamp_gate(h_in);
                  n_q     <= clamp_gate(n_in);
                  i_ext_q <= i_ext;
                  dt_q    <= dt;
                  busy    <= 1'b1;
                  state_q <= StNa1;
               end
            end
            StNa1: begin a_q <= prod_div;    state_q <= StNa2;  end
            StNa2: begin a_q <= prod_div;    state_q <= StNa3;  end
            StNa3: begin a_q <= prod_div;    state_q <= StNa4;  end
            StNa4: begin t_q <= prod;        state_q <= StNa5;  end
            StNa5: begin i_na_q <= prod_div; state_q <= StK1;   end
            StK1:  begin b_q <= prod_div;    state_q <= StK2;   end
            StK2:  begin b_q <= prod_div;    state_q <= StK3;   end
            StK3:  begin t_q <= prod;        state_q <= StK4;   end
            StK4:  begin i_k_q <= prod_div;  state_q <= StL;    end
            StL:   begin i_l_q <= prod;      state_q <= StSum;  end
            StSum: begin
               s_q     <= dp_t'(i_ext_q) - i_na_q - i_k_q - i_l_q;
               state_q <= StScale;
            end
            StScale: begin p_q <= prod;      state_q <= StUpd;  end
            StUpd: begin
               v_next  <= v_sat;
               done    <= 1'b1;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hh_membrane_update.sv
// Scoreboard bench for hh_membrane_update: stimulus pushes expected potentials and done cycles,
// a negedge monitor pops and compares whenever done is seen.
module tb_hh_membrane_update;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic signed [15:0] v_in = '0;
   logic        [15:0] m_in = '0;
   logic        [15:0] h_in = '0;
   logic        [15:0] n_in = '0;
   logic signed [15:0] i_ext = '0;
   logic        [15:0] dt = '0;
   logic signed [15:0] v_next;
   logic               busy;
   logic               done;

   typedef struct {
      int v;
      int cyc;
      int id;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   hh_membrane_update dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .v_in   (v_in),
      .m_in   (m_in),
      .h_in   (h_in),
      .n_in   (n_in),
      .i_ext  (i_ext),
      .dt     (dt),
      .v_next (v_next),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", int'(done), 0);
         end else begin
            e = sb.pop_front();
            check($sformatf("v_next[%0d]", e.id), int'(v_next), e.v);
            check($sformatf("done_cycle[%0d]", e.id), cyc, e.cyc);
         end
      end
   end

   task automatic drive(input int v, input int m, input int h, input int n, input int i,
                        input int d);
      v_in  = 16'(v);
      m_in  = 16'(m);
      h_in  = 16'(h);
      n_in  = 16'(n);
      i_ext = 16'(i);
      dt    = 16'(d);
   endtask

   task automatic scramble();
      v_in  = 16'sh3abc;
      m_in  = 16'd777;
      h_in  = 16'd123;
      n_in  = 16'd999;
      i_ext = -16'sd2500;
      dt    = 16'd4321;
   endtask

   // One complete update; inputs are scrambled right after the start edge.
   task automatic issue(input int id, input int v, input int m, input int h, input int n,
                        input int i, input int d, input int req);
      @(negedge clk);
      drive(v, m, h, n, i, d);
      start = 1'b1;
      sb.push_back('{v: req, cyc: cyc + 14, id: id});
      @(negedge clk);
      start = 1'b0;
      scramble();
      check($sformatf("busy_rise[%0d]", id), int'(busy), 1);
      repeat (13) @(negedge clk);
      check($sformatf("busy_fall[%0d]", id), int'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("reset_v_next", int'(v_next), -6500);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      reset = 1'b0;

      issue(1, -6500, 53, 596, 318, 0, 10, -6501);
      issue(2, -5440, 0, 0, 0, 10000, 10, -5430);
      issue(3, -5440, 0, 0, 0, 32767, 65535, 32767);
      issue(4, -5440, 0, 0, 0, -32768, 65535, -32768);
      issue(5, 0, 2000, 2000, 0, 0, 10, 5983);
      issue(6, 0, 1000, 1000, 0, 0, 10, 5983);

      // Start pulses while busy must be ignored.
      @(negedge clk);
      drive(-6500, 53, 596, 318, 0, 10);
      start = 1'b1;
      sb.push_back('{v: -6501, cyc: cyc + 14, id: 7});
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      drive(1000, 1000, 1000, 0, 30000, 1000);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      repeat (3) @(negedge clk);
      check("v_next_held", int'(v_next), -6501);

      // Start held high: back-to-back updates every 14 cycles.
      @(negedge clk);
      drive(-6500, 53, 596, 318, 0, 10);
      start = 1'b1;
      sb.push_back('{v: -6501, cyc: cyc + 14, id: 8});
      sb.push_back('{v: -6501, cyc: cyc + 28, id: 9});
      repeat (15) @(negedge clk);
      start = 1'b0;
      repeat (13) @(negedge clk);

      issue(10, 1234, 500, 300, 700, -2000, 0, 1234);

      // Reset during NA3 aborts without a done pulse.
      @(negedge clk);
      drive(-6500, 53, 596, 318, 0, 10);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_v_next", int'(v_next), -6500);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      reset = 1'b0;
      repeat (14) @(negedge clk);

      issue(11, -5440, 0, 0, 0, 10000, 10, -5430);

      for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
